// File: rtl/spi_fetch_seq_pkg.sv
// -----------------------------------------------------------------------------
// spi_fetch_seq_pkg
//   Shared definitions for the multi-byte SPI RAM fetch sequencer:
//   - fetch_state_t : FSM state encoding (IDLE, ISSUE, WAIT, RESP)
//   - SPI_OP_READ   : READ opcode issued by the downstream byte reader
//   - ADDR_W        : byte address width of the serial RAM
//   - next_addr()   : address increment with wrap at the top of the 64 KiB space
// -----------------------------------------------------------------------------
package spi_fetch_seq_pkg;

  localparam int         ADDR_W      = 16;
  localparam logic [7:0] SPI_OP_READ = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } fetch_state_t;

  // Next sequential byte address; 0xFFFF rolls over to 0x0000 naturally.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
    return addr + 16'd1;
  endfunction

endpackage

// File: rtl/spi_fetch_seq.sv
// -----------------------------------------------------------------------------
// spi_fetch_seq
//   Multi-byte fetch sequencer placed in front of the single-byte SPI RAM
//   reader. One CPU request (start address plus 1..MAX_BYTES bytes) becomes a
//   series of byte reads at incrementing addresses; the returned bytes are
//   packed little-endian into one response word. A per-byte watchdog aborts
//   the request if the reader never reports completion.
//
// Parameters
//   MAX_BYTES   bytes per request (response word is 8*MAX_BYTES bits)
//   LEN_W       width of req_len, byte count minus one (2**LEN_W == MAX_BYTES)
//   TIMEOUT_CYC WAIT cycles per byte before abort (8-bit counter, >= 60 so a
//               healthy 52-cycle reader never trips it)
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   req_valid/req_ready    CPU request handshake (ready only while idle)
//   req_addr, req_len      start address, byte count minus one
//   rsp_valid/rsp_ready    response handshake, response held until consumed
//   rsp_data, rsp_err      packed bytes (unread lanes 0), watchdog abort flag
//   rd_start, rd_addr      one-cycle start pulse and address to byte reader
//   rd_busy, rd_done       reader busy level, one-cycle completion pulse
//   rd_data                byte returned by the reader with rd_done
// -----------------------------------------------------------------------------
module spi_fetch_seq
  import spi_fetch_seq_pkg::*;
#(
  parameter int MAX_BYTES   = 4,
  parameter int LEN_W       = 2,
  parameter int TIMEOUT_CYC = 127
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [LEN_W-1:0]       req_len,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [8*MAX_BYTES-1:0] rsp_data,
  output logic                   rsp_err,
  output logic                   rd_start,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic                   rd_busy,
  input  logic                   rd_done,
  input  logic [7:0]             rd_data
);

  localparam int DATA_W = 8 * MAX_BYTES;
  // Abort fires on the cycle the counter would reach TIMEOUT_CYC.
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYC - 1);

  fetch_state_t        state_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [LEN_W-1:0]    len_r;
  logic [LEN_W-1:0]    cnt_r;
  logic [7:0]          wdog_r;
  logic                req_ready_r;
  logic                rsp_valid_r;
  logic                rsp_err_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic                rd_start_r;
  logic [ADDR_W-1:0]   rd_addr_r;

  logic                accept_s;
  logic                last_byte_s;
  logic                wdog_expired_s;

  // Write one byte into the selected lane of the response word; other lanes
  // are left untouched so earlier bytes survive an abort.
  function automatic logic [DATA_W-1:0] put_lane(
    input logic [DATA_W-1:0] word,
    input logic [LEN_W-1:0]  lane,
    input logic [7:0]        b
  );
    logic [DATA_W-1:0] w;
    w = word;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (lane == LEN_W'(k)) begin
        w[8*k +: 8] = b;
      end
    end
    return w;
  endfunction

  // Handshake and progress decodes used by the FSM.
  always_comb begin
    accept_s       = 1'b0;
    last_byte_s    = 1'b0;
    wdog_expired_s = 1'b0;
    // req_ready_r is only ever high in IDLE, so it qualifies the accept alone.
    if (req_valid && req_ready_r) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if (cnt_r == len_r) begin
      last_byte_s = 1'b1;
    end else begin
      last_byte_s = 1'b0;
    end
    if (wdog_r == WDOG_LAST) begin
      wdog_expired_s = 1'b1;
    end else begin
      wdog_expired_s = 1'b0;
    end
  end

  // Fetch FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      len_r       <= {LEN_W{1'b0}};
      cnt_r       <= {LEN_W{1'b0}};
      wdog_r      <= 8'd0;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_data_r  <= {DATA_W{1'b0}};
      rd_start_r  <= 1'b0;
      rd_addr_r   <= {ADDR_W{1'b0}};
    end else begin
      // rd_start is a single-cycle pulse unless ISSUE re-asserts it.
      rd_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            addr_r      <= req_addr;
            len_r       <= req_len;
            cnt_r       <= {LEN_W{1'b0}};
            rsp_data_r  <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
            req_ready_r <= 1'b0;
            state_r     <= ST_ISSUE;
          end else begin
            req_ready_r <= 1'b1;
          end
        end

        ST_ISSUE: begin
          if (!rd_busy) begin
            rd_start_r <= 1'b1;
            rd_addr_r  <= addr_r;
            wdog_r     <= 8'd0;
            state_r    <= ST_WAIT;
          end else begin
            state_r <= ST_ISSUE;
          end
        end

        ST_WAIT: begin
          // rd_busy rises a cycle after rd_start, so only rd_done is trusted here.
          // Completion takes priority over a coincident watchdog expiry.
          if (rd_done) begin
            rsp_data_r <= put_lane(rsp_data_r, cnt_r, rd_data);
            if (last_byte_s) begin
              rsp_valid_r <= 1'b1;
              state_r     <= ST_RESP;
            end else begin
              cnt_r   <= cnt_r + LEN_W'(1'b1);
              addr_r  <= next_addr(addr_r);
              state_r <= ST_ISSUE;
            end
          end else if (wdog_expired_s) begin
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end else begin
            wdog_r <= wdog_r + 8'd1;
          end
        end

        ST_RESP: begin
          // req_ready comes back registered, so the next accept is at least one
          // cycle after the response handshake.
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          req_ready_r <= 1'b0;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_data  = rsp_data_r;
  assign rd_start  = rd_start_r;
  assign rd_addr   = rd_addr_r;

endmodule

// File: tb/tb_spi_fetch_seq.sv
// -----------------------------------------------------------------------------
// tb_spi_fetch_seq
//   Self-checking bench for spi_fetch_seq. A behavioural byte reader backs a
//   23LC512 image with mem[a] = a[7:0] ^ 0x5A and random per-byte latency; it
//   can be told to stop answering after a given number of reads. Expected
//   response words and address sequences are computed from the request alone.
// -----------------------------------------------------------------------------
module tb_spi_fetch_seq;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic [1:0]  req_len;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rd_start;
  logic [15:0] rd_addr;
  logic        rd_busy;
  logic        rd_done;
  logic [7:0]  rd_data;

  int n_checks;
  int n_pass;

  // reader model state
  logic        mdl_busy;
  logic        mdl_done;
  logic [7:0]  mdl_data;
  logic [15:0] mdl_addr;
  int          mdl_left;
  int          served_n;
  int          serve_limit;
  logic        spur_done;
  logic [15:0] issued_q[$];

  spi_fetch_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rd_start  (rd_start),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy),
    .rd_done   (rd_done),
    .rd_data   (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rd_busy = mdl_busy;
  assign rd_done = mdl_done | spur_done;
  assign rd_data = spur_done ? 8'hFF : mdl_data;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Little-endian packing of nbytes consecutive bytes starting at addr.
  function automatic logic [31:0] exp_word(input logic [15:0] addr, input int nbytes);
    logic [31:0] w;
    logic [15:0] a;
    w = 32'd0;
    for (int k = 0; k < nbytes; k++) begin
      a = 16'((32'(addr) + k) % 65536);
      w = w | (32'(mem_byte(a)) << (8 * k));
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural byte reader: busy one cycle after start, done after a random delay.
  always @(posedge clk) begin
    mdl_done <= 1'b0;
    if (!rst_n) begin
      mdl_busy <= 1'b0;
      mdl_left <= 0;
    end else if (rd_start) begin
      issued_q.push_back(rd_addr);
      if (serve_limit < 0 || served_n < serve_limit) begin
        served_n <= served_n + 1;
        mdl_busy <= 1'b1;
        mdl_addr <= rd_addr;
        mdl_left <= int'($urandom_range(2, 52));
      end
    end else if (mdl_busy) begin
      if (mdl_left <= 1) begin
        chk("rd_addr_stable", 32'(rd_addr), 32'(mdl_addr));
        mdl_busy <= 1'b0;
        mdl_done <= 1'b1;
        mdl_data <= mem_byte(mdl_addr);
      end else begin
        mdl_left <= mdl_left - 1;
      end
    end
  end

  task automatic wait_ready();
    int cyc;
    cyc = 0;
    while (req_ready !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  // One full request. nserve < 0: reader answers every byte; otherwise it
  // answers only nserve more reads and then hangs. bp = cycles of rsp_ready=0.
  task automatic do_req(input logic [15:0] addr, input logic [1:0] len,
                        input int nserve, input int bp);
    int          base, cyc, nbytes, nstarts, got_starts;
    logic        err_exp, ok;
    logic [31:0] held;
    base        = issued_q.size();
    serve_limit = (nserve < 0) ? -1 : served_n + nserve;
    wait_ready();
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = len;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 16'($urandom);
    req_len   = 2'($urandom);
    chk("req_ready_drop", 32'(req_ready), 32'd0);

    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);

    err_exp = (nserve >= 0) && (nserve <= int'(len));
    nbytes  = err_exp ? nserve : int'(len) + 1;
    nstarts = err_exp ? nserve + 1 : int'(len) + 1;
    if (nserve == 0) begin
      chk("timeout_latency", 32'((cyc >= 128) && (cyc <= 129)), 32'd1);
    end
    chk("rsp_data", rsp_data, exp_word(addr, nbytes));
    chk("rsp_err", 32'(rsp_err), 32'(err_exp));
    got_starts = issued_q.size() - base;
    chk("rd_start_count", 32'(got_starts), 32'(nstarts));
    for (int k = 0; k < nstarts && k < got_starts; k++) begin
      chk("rd_addr_seq", 32'(issued_q[base + k]), (32'(addr) + 32'(k)) % 32'd65536);
    end

    // Hold the response; a stray rd_done during RESP must not disturb it.
    held = rsp_data;
    ok   = 1'b1;
    for (int i = 0; i < bp; i++) begin
      spur_done = (i == 0);
      @(negedge clk);
      ok = ok & (rsp_valid === 1'b1) & (rsp_data === held) &
           (req_ready === 1'b0) & (rsp_err === err_exp);
    end
    spur_done = 1'b0;
    if (bp > 0) begin
      chk("backpressure_stable", 32'(ok), 32'd1);
    end

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("req_ready_return", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int base, cyc;
    n_checks    = 0;
    n_pass      = 0;
    served_n    = 0;
    serve_limit = -1;
    spur_done   = 1'b0;
    req_valid   = 1'b0;
    req_addr    = 16'd0;
    req_len     = 2'd0;
    rsp_ready   = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);

    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_err",   32'(rsp_err),   32'd0);
    chk("reset_rsp_data",  rsp_data,       32'd0);
    chk("reset_rd_start",  32'(rd_start),  32'd0);
    chk("reset_rd_addr",   32'(rd_addr),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_ready_after_reset", 32'(req_ready), 32'd1);

    // Directed cases
    do_req(16'h1234, 2'd0, -1, 0);
    do_req(16'h0100, 2'd3, -1, 0);
    do_req(16'hFFFE, 2'd3, -1, 0);
    do_req(16'h4321, 2'd2, -1, 20);
    chk("rd_addr_held_idle", 32'(rd_addr), 32'h4323);
    do_req(16'h2000, 2'd1, 0, 3);   // reader never answers
    do_req(16'h3000, 2'd3, 2, 2);   // two bytes arrive, third hangs

    // Randomised requests
    for (int t = 0; t < 10; t++) begin
      do_req(16'($urandom), 2'($urandom), -1, int'($urandom_range(0, 4)));
    end

    // Reset during byte 2 of 4
    serve_limit = -1;
    base = issued_q.size();
    wait_ready();
    req_valid = 1'b1;
    req_addr  = 16'h7FF0;
    req_len   = 2'd3;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while ((issued_q.size() - base) < 2 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("midop_second_byte", 32'((issued_q.size() - base) >= 2), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midop_rd_start",  32'(rd_start),  32'd0);
    chk("midop_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midop_req_ready", 32'(req_ready), 32'd0);
    chk("midop_rsp_data",  rsp_data,       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(16'($urandom), 2'd3, -1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
